// File: rtl/btn_debounce_scen.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_scen
// Brief    : Push-button debouncer producing a debounced level (DPB), a single
//            pulse per press (SCEN) and an auto-repeat enable (MCEN).
// Option   : define BTN_REPEAT_EN to enable the auto-repeat path.
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce_scen #(
  parameter int DB_CYCLES     = 2500000,
  parameter int REPEAT_CYCLES = 50000000,
  parameter int CNT_W         = 26
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic [2:0] q_state
);

  typedef enum logic [2:0] {
    INI     = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    WH      = 3'd3,
    MCEN_ST = 3'd4,
    CCR     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_db_last  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rpt_last = CNT_W'(REPEAT_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             w_pb_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_wrap;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= PB;
      r_s2 <= r_s1;
    end
  end

  assign w_pb_s = r_s2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_wrap  = 1'b0;
    case (r_state)
      INI: begin
        if (w_pb_s) w_state_nxt = WQ;
      end
      WQ: begin
        if (!w_pb_s)                 w_state_nxt = INI;
        else if (r_cnt == c_db_last) w_state_nxt = SCEN_ST;
      end
      SCEN_ST: begin
        w_state_nxt = WH;
      end
      WH: begin
        if (!w_pb_s) begin
          w_state_nxt = CCR;
        end else if (r_cnt == c_rpt_last) begin
`ifdef BTN_REPEAT_EN
          w_state_nxt = MCEN_ST;
`else
          // No repeat: just restart the hold count so it never overflows.
          w_cnt_wrap  = 1'b1;
`endif
        end
      end
      MCEN_ST: begin
        w_state_nxt = WH;
      end
      CCR: begin
        if (w_pb_s)                  w_state_nxt = WH;
        else if (r_cnt == c_db_last) w_state_nxt = INI;
      end
      default: begin
        w_state_nxt = INI;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= INI;
      r_cnt   <= '0;
      DPB     <= 1'b0;
      SCEN    <= 1'b0;
      MCEN    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || w_cnt_wrap)
        r_cnt <= '0;
      else if ((r_state == WQ) || (r_state == WH) || (r_state == CCR))
        r_cnt <= r_cnt + CNT_W'(1);
      DPB  <= (w_state_nxt == SCEN_ST) || (w_state_nxt == WH) ||
              (w_state_nxt == MCEN_ST) || (w_state_nxt == CCR);
      SCEN <= (w_state_nxt == SCEN_ST);
`ifdef BTN_REPEAT_EN
      MCEN <= (w_state_nxt == SCEN_ST) || (w_state_nxt == MCEN_ST);
`else
      MCEN <= (w_state_nxt == SCEN_ST);
`endif
    end
  end

  assign q_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_scen.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_scen
// Brief    : Scoreboard bench for btn_debounce_scen using a run-length model.
// Revision : 1.0  initial release
// ============================================================================
module tb_btn_debounce_scen;

  localparam int c_db  = 4;
  localparam int c_rpt = 8;
`ifdef BTN_REPEAT_EN
  localparam bit c_rep = 1'b1;
`else
  localparam bit c_rep = 1'b0;
`endif

  logic       board_clk;
  logic       Reset;
  logic       PB;
  logic       DPB;
  logic       SCEN;
  logic       MCEN;
  logic [2:0] q_state;

  btn_debounce_scen #(
    .DB_CYCLES    (c_db),
    .REPEAT_CYCLES(c_rpt),
    .CNT_W        (4)
  ) dut (
    .board_clk(board_clk),
    .Reset    (Reset),
    .PB       (PB),
    .DPB      (DPB),
    .SCEN     (SCEN),
    .MCEN     (MCEN),
    .q_state  (q_state)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  typedef struct {
    int cyc;
    bit scen;
    bit mcen;
  } pulse_t;

  pulse_t     exp_q[$];
  int         n_chk = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         n_scen = 0;
  int         n_mcen = 0;
  logic [7:0] seen_q = '0;

  // Reference model: debounced level from run lengths of the synchronized input.
  bit m_s1 = 0, m_s2 = 0, m_lvl = 0, m_skip = 0;
  int m_ones = 0, m_zeros = 0, m_hold = 0;

  initial begin
    bit p;
    forever begin
      @(posedge board_clk or posedge Reset);
      #1;
      if (Reset) begin
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_skip = 0;
        m_ones = 0; m_zeros = 0; m_hold = 0;
      end else begin
        cyc++;
        p    = m_s2;
        m_s2 = m_s1;
        m_s1 = PB;
        if (!m_lvl) begin
          m_ones = p ? m_ones + 1 : 0;
          if (m_ones == c_db + 1) begin
            exp_q.push_back('{cyc: cyc, scen: 1'b1, mcen: 1'b1});
            m_lvl = 1; m_skip = 1; m_ones = 0;
          end
        end else if (m_skip) begin
          m_skip = 0; m_zeros = 0; m_hold = 0;
        end else if (!p) begin
          m_hold = 0;
          m_zeros++;
          if (m_zeros == c_db + 1) begin
            m_lvl = 0; m_zeros = 0;
          end
        end else if (m_zeros > 0) begin
          m_zeros = 0; m_hold = 0;
        end else begin
          m_hold++;
          if (c_rep && m_hold == c_rpt) begin
            exp_q.push_back('{cyc: cyc, scen: 1'b0, mcen: 1'b1});
            m_skip = 1;
          end
        end
      end
    end
  end

  initial begin
    pulse_t e;
    forever begin
      @(negedge board_clk);
      seen_q[q_state] = 1'b1;
      n_chk++;
      if (DPB !== m_lvl) begin
        n_bad++;
        $display("FAIL dpb cyc=%0d got=%b want=%b", cyc, DPB, m_lvl);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_chk++;
        n_bad++;
        $display("FAIL pulse_missed cyc=%0d got=none want=pulse@%0d", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (SCEN === 1'b1 || MCEN === 1'b1) begin
        if (SCEN === 1'b1) n_scen++;
        if (MCEN === 1'b1) n_mcen++;
        n_chk++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_bad++;
          $display("FAIL pulse_unexpected cyc=%0d got=scen%b/mcen%b want=none", cyc, SCEN, MCEN);
        end else begin
          e = exp_q.pop_front();
          if (SCEN !== e.scen || MCEN !== e.mcen) begin
            n_bad++;
            $display("FAIL pulse_kind cyc=%0d got=scen%b/mcen%b want=scen%b/mcen%b",
                     cyc, SCEN, MCEN, e.scen, e.mcen);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      PB = v;
      @(negedge board_clk);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    bit got3;
    PB    = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge board_clk);
    #1;
    check("reset_outputs", {DPB, SCEN, MCEN}, 0);
    check("reset_state", q_state, 0);
    Reset = 1'b0;

    // Short glitch never leaves the qualify state.
    seen_q = '0;
    drive(1'b1, 3);
    drive(1'b0, 12);
    #1;
    check("glitch_states", seen_q, 8'h03);
    check("glitch_end", q_state, 0);

    // Clean long hold: one SCEN plus repeats only when enabled.
    n_scen = 0;
    n_mcen = 0;
    drive(1'b1, 40);
    drive(1'b0, 15);
    #1;
    check("hold_scen_count", n_scen, 1);
    check("hold_mcen_count", n_mcen, c_rep ? 4 : 1);
    check("hold_release_state", q_state, 0);

    // Short release bounce must not re-trigger.
    n_scen = 0;
    seen_q = '0;
    drive(1'b1, 12);
    drive(1'b0, 2);
    drive(1'b1, 6);
    #1;
    check("bounce_ccr_seen", seen_q[5], 1);
    check("bounce_back_wh", q_state, 3);
    check("bounce_dpb", DPB, 1);
    check("bounce_scen_count", n_scen, 1);
    drive(1'b0, 15);

    // Reset while holding, then the held button counts as a new press.
    got3 = 1'b0;
    for (int i = 0; i < 20 && !got3; i++) begin
      PB = 1'b1;
      @(negedge board_clk);
      if (q_state == 3'd3) got3 = 1'b1;
    end
    check("midhold_reach_wh", got3, 1);
    #2 Reset = 1'b1;
    #1;
    check("midhold_reset_outputs", {DPB, SCEN, MCEN, q_state}, 0);
    @(negedge board_clk);
    @(negedge board_clk);
    Reset  = 1'b0;
    n_scen = 0;
    drive(1'b1, 12);
    drive(1'b0, 15);
    #1;
    check("midhold_scen_count", n_scen, 1);

    // Random bouncy traffic.
    for (int s = 0; s < 200; s++) begin
      logic v;
      int   n;
      v = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 5));
      drive(v, n);
    end

    drive(1'b0, 20);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("final_idle", q_state, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
